// File: rtl/mac_stream_engine.sv
// mac_stream_engine: lane-parallel FP multiply, adder-tree reduction, optional packet accumulation,
// credit-controlled output FIFO. Arithmetic truncates, flushes subnormals to zero and saturates to infinity.
module fp_add_comb #(parameter int F = 24, E = 8) (
  input  logic [F+E-1:0] a_i,
  input  logic [F+E-1:0] b_i,
  output logic [F+E-1:0] y_o
);
  localparam int W = F + E;
  logic a_big;
  logic [W-1:0] bg, sm;
  logic [E-1:0] d;
  logic [F:0] mb, ms, r;
  logic [F-2:0] mant;
  int lz, ee;
  always_comb begin
    a_big = a_i[W-2:0] >= b_i[W-2:0];
    bg = a_big ? a_i : b_i;
    sm = a_big ? b_i : a_i;
    d = bg[W-2 -: E] - sm[W-2 -: E];
    mb = {2'b01, bg[F-2:0]};
    ms = (sm[W-2 -: E] == '0) ? '0 : ({2'b01, sm[F-2:0]} >> d);
    r = (bg[W-1] == sm[W-1]) ? mb + ms : mb - ms;
    lz = 0;
    for (int i = 0; i < F; i++) if (r[i]) lz = F - 1 - i;
    mant = r[F] ? r[F-1:1] : (F-1)'(r << lz);
    ee = int'(bg[W-2 -: E]) + (r[F] ? 1 : -lz);
    y_o = (bg[W-2 -: E] == '0 || r == '0 || ee <= 0) ? '0 :
          (ee >= 2**E - 1) ? {bg[W-1], {E{1'b1}}, {(F-1){1'b0}}} : {bg[W-1], E'(ee), mant};
  end
endmodule

module floating_point_multiply #(parameter int F = 24, E = 8) (
  input  logic           clk,
  input  logic           rst,
  input  logic [F+E-1:0] a_i,
  input  logic [F+E-1:0] b_i,
  output logic [F+E-1:0] y_o
);
  localparam int W = F + E;
  localparam int LAT = 10;
  logic [2*F-1:0] p;
  logic [F-2:0] mant;
  logic [W-1:0] y;
  logic [LAT-1:0][W-1:0] q_q;
  int ee;
  always_comb begin
    p = {1'b1, a_i[F-2:0]} * {1'b1, b_i[F-2:0]};
    mant = (F-1)'((p << !p[2*F-1]) >> F);
    ee = int'(a_i[W-2 -: E]) + int'(b_i[W-2 -: E]) - (2**(E-1) - 1) + int'(p[2*F-1]);
    y = (a_i[W-2 -: E] == '0 || b_i[W-2 -: E] == '0 || ee <= 0) ? '0 :
        (ee >= 2**E - 1) ? {a_i[W-1] ^ b_i[W-1], {E{1'b1}}, {(F-1){1'b0}}} :
        {a_i[W-1] ^ b_i[W-1], E'(ee), mant};
  end
  always_ff @(posedge clk) q_q <= rst ? '0 : {q_q[LAT-2:0], y};
  assign y_o = q_q[LAT-1];
endmodule

module floating_point_add #(parameter int F = 24, E = 8) (
  input  logic           clk,
  input  logic           rst,
  input  logic [F+E-1:0] a_i,
  input  logic [F+E-1:0] b_i,
  output logic [F+E-1:0] y_o
);
  localparam int LAT = 13;
  logic [F+E-1:0] y;
  logic [LAT-1:0][F+E-1:0] q_q;
  fp_add_comb #(.F(F), .E(E)) u_add (.a_i, .b_i, .y_o(y));
  always_ff @(posedge clk) q_q <= rst ? '0 : {q_q[LAT-2:0], y};
  assign y_o = q_q[LAT-1];
endmodule

module floating_point_accumulator #(parameter int F = 24, E = 8) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  input  logic           first_i,
  input  logic           last_i,
  input  logic [F+E-1:0] data_i,
  output logic [F+E-1:0] data_o,
  output logic           valid_o
);
  logic [F+E-1:0] acc_q, sum, nxt;
  fp_add_comb #(.F(F), .E(E)) u_add (.a_i(acc_q), .b_i(data_i), .y_o(sum));
  assign nxt = first_i ? data_i : sum;
  always_ff @(posedge clk)
    if (rst) begin
      acc_q <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i && last_i;
      if (valid_i) acc_q <= nxt;
      if (valid_i && last_i) data_o <= nxt;
    end
endmodule

module mac_stream_engine #(
  parameter int FRAC_WIDTH = 24,
  parameter int EXP_WIDTH = 8,
  parameter int VECTOR_SIZE = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                         clkIn,
  input  logic                                         rstIn,
  input  logic                                         modeIn,
  input  logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] dataAIn,
  input  logic [(FRAC_WIDTH+EXP_WIDTH)*VECTOR_SIZE-1:0] dataBIn,
  input  logic [VECTOR_SIZE-1:0]                       laneMaskIn,
  input  logic                                         validIn,
  input  logic                                         lastIn,
  output logic                                         readyOut,
  output logic [FRAC_WIDTH+EXP_WIDTH-1:0]              dataOut,
  output logic                                         validOut,
  input  logic                                         readyIn,
  output logic [$clog2(FIFO_DEPTH):0]                  fifoCountOut
);
  localparam int DW = FRAC_WIDTH + EXP_WIDTH;
  localparam int NUM_STAGES = $clog2(VECTOR_SIZE);
  localparam int P = 2 ** NUM_STAGES;
  localparam int TREE_LATENCY = 10 + 13 * NUM_STAGES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TL = TREE_LATENCY;
  logic rst;
  logic [DW-1:0] node [1:2*P-1];
  logic [TL-1:0] v_q, m_q, f_q, l_q;
  logic in_pkt_q, pkt_mode_q, first, cur_mode, accept, rd, wr, acc_v;
  logic [DW-1:0] acc_d, wdata;
  logic [CW-1:0] credits_q, credits_d, count_q, count_d, in_flight;
  logic [AW-1:0] wp_q, rp_q;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  assign rst = !rstIn;
  // Heap-indexed tree: leaves at P..2P-1, root at 1; pad leaves are constant +0.0.
  for (genvar j = 0; j < P; j++) begin : g_lane
    if (j < VECTOR_SIZE) begin : g_mul
      floating_point_multiply #(.F(FRAC_WIDTH), .E(EXP_WIDTH)) u_mul (
        .clk(clkIn), .rst,
        .a_i(laneMaskIn[j] ? dataAIn[j*DW +: DW] : '0),
        .b_i(dataBIn[j*DW +: DW]),
        .y_o(node[P+j]));
    end else begin : g_pad
      assign node[P+j] = '0;
    end
  end
  for (genvar i = 1; i < P; i++) begin : g_tree
    floating_point_add #(.F(FRAC_WIDTH), .E(EXP_WIDTH)) u_add (
      .clk(clkIn), .rst, .a_i(node[2*i]), .b_i(node[2*i+1]), .y_o(node[i]));
  end
  floating_point_accumulator #(.F(FRAC_WIDTH), .E(EXP_WIDTH)) u_acc (
    .clk(clkIn), .rst, .valid_i(v_q[TL-1] && m_q[TL-1]), .first_i(f_q[TL-1]),
    .last_i(l_q[TL-1]), .data_i(node[1]), .data_o(acc_d), .valid_o(acc_v));
  // Mode changes wait for an empty pipeline so results never reorder.
  assign first = !in_pkt_q;
  assign cur_mode = in_pkt_q ? pkt_mode_q : modeIn;
  assign in_flight = credits_q - count_q;
  assign readyOut = rstIn && !(first && credits_q == CW'(FIFO_DEPTH)) &&
                    !(first && validIn && modeIn != pkt_mode_q && in_flight != '0);
  assign accept = validIn && readyOut;
  assign rd = validOut && readyIn;
  assign wr = (v_q[TL-1] && !m_q[TL-1]) || acc_v;
  assign wdata = acc_v ? acc_d : node[1];
  assign credits_d = credits_q + CW'(accept && first) - CW'(rd);
  assign count_d = count_q + CW'(wr) - CW'(rd);
  assign validOut = count_q != '0;
  assign dataOut = validOut ? mem_q[rp_q] : '0;
  assign fifoCountOut = count_q;
  always_ff @(posedge clkIn)
    if (!rstIn) begin
      {v_q, m_q, f_q, l_q} <= '0;
      {in_pkt_q, pkt_mode_q} <= '0;
      {credits_q, count_q, wp_q, rp_q} <= '0;
    end else begin
      v_q <= {v_q[TL-2:0], accept};
      m_q <= {m_q[TL-2:0], cur_mode};
      f_q <= {f_q[TL-2:0], first};
      l_q <= {l_q[TL-2:0], lastIn};
      if (accept && first) pkt_mode_q <= modeIn;
      if (accept) in_pkt_q <= cur_mode && !lastIn;
      credits_q <= credits_d;
      count_q <= count_d;
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
    end
  always_ff @(posedge clkIn) if (wr) mem_q[wp_q] <= wdata;
endmodule
